// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared types and constants for the timebase controller
package timebase_pkg;

  typedef enum logic [1:0] {
    LOAD        = 2'b00,
    START       = 2'b01,
    STOP        = 2'b10,
    TOGGLE_MODE = 2'b11
  } cfg_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } ctrl_state_e;

  localparam int unsigned DEF_PERIOD_C = 32'd268435456;

  // Channel-select width; a single-channel build still carries one select bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timebase_if.sv
// rtl/timebase_if.sv - configuration command port of the timebase controller
interface timebase_if #(
  parameter int N_CH = 4,
  parameter int W    = 32
);
  import timebase_pkg::*;

  localparam int CH_W = ch_w(N_CH);

  logic            cfg_valid;
  logic            cfg_ready;
  cfg_op_e         cfg_op;
  logic [CH_W-1:0] cfg_ch;
  logic [W-1:0]    cfg_period;
  logic            cfg_oneshot;
  logic            cfg_err;

  modport master (
    output cfg_valid, cfg_op, cfg_ch, cfg_period, cfg_oneshot,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_ch, cfg_period, cfg_oneshot,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/timebase_channel.sv
// rtl/timebase_channel.sv - one programmable tick/clk_slow generator
module timebase_channel
  import timebase_pkg::*;
#(
  parameter int           W          = 32,
  parameter logic [W-1:0] DEF_PERIOD = W'(DEF_PERIOD_C),
  parameter bit           RST_RUN    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         start,
  input  logic         stop,
  input  logic         toggle,
  input  logic [W-1:0] ld_period,
  input  logic         ld_oneshot,
  output logic         tick,
  output logic         clk_slow,
  output logic         running
);

  logic [W-1:0] count_q;
  logic [W-1:0] period_q;
  logic         oneshot_q;
  logic         run_q;
  logic         slow_q;

  assign tick     = run_q && (count_q == period_q - W'(1));
  assign clk_slow = slow_q;
  assign running  = run_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      period_q  <= DEF_PERIOD;
      oneshot_q <= 1'b0;
      run_q     <= RST_RUN;
      slow_q    <= 1'b0;
    end else begin
      if (run_q) begin
        if (tick) begin
          count_q <= '0;
          slow_q  <= ~slow_q;
          if (oneshot_q) run_q <= 1'b0;
        end else begin
          count_q <= count_q + W'(1);
        end
      end
      // Commands land after the counter update so their writes win on a tick edge.
      if (ld) begin
        period_q  <= ld_period;
        oneshot_q <= ld_oneshot;
        count_q   <= '0;
        slow_q    <= 1'b0;
        run_q     <= 1'b0;
      end else if (start) begin
        count_q <= '0;
        run_q   <= 1'b1;
      end else if (stop) begin
        run_q <= 1'b0;
      end else if (toggle) begin
        oneshot_q <= ~oneshot_q;
      end
    end
  end

endmodule

// File: rtl/timebase_ctrl.sv
// rtl/timebase_ctrl.sv - command FSM and channel array of the timebase controller
module timebase_ctrl
  import timebase_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter int              W          = 32,
  parameter logic [W-1:0]    DEF_PERIOD = W'(DEF_PERIOD_C),
  parameter logic [N_CH-1:0] RST_RUN    = N_CH'(1)
) (
  input  logic            clk,
  input  logic            rst_n,
  timebase_if.slave       cfg,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] clk_slow,
  output logic [N_CH-1:0] running
);

  localparam int CH_W = ch_w(N_CH);

  ctrl_state_e     state;
  logic            ready_q;
  logic            err_q;
  cfg_op_e         cmd_op;
  logic [CH_W-1:0] cmd_ch;
  logic [W-1:0]    cmd_period;
  logic            cmd_oneshot;
  logic            cmd_bad;

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

  assign cmd_bad = (32'(cfg.cfg_ch) >= 32'(N_CH)) ||
                   ((cfg.cfg_op == LOAD) && (cfg.cfg_period == '0));

  // err_q doubles as the reject flag for the command held in APPLY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      cmd_op      <= LOAD;
      cmd_ch      <= '0;
      cmd_period  <= '0;
      cmd_oneshot <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            cmd_op      <= cfg.cfg_op;
            cmd_ch      <= cfg.cfg_ch;
            cmd_period  <= cfg.cfg_period;
            cmd_oneshot <= cfg.cfg_oneshot;
            err_q       <= cmd_bad;
            ready_q     <= 1'b0;
            state       <= APPLY;
          end
        end
        APPLY: begin
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel;

    assign sel = (state == APPLY) && !err_q && (cmd_ch == CH_W'(i));

    timebase_channel #(
      .W          (W),
      .DEF_PERIOD (DEF_PERIOD),
      .RST_RUN    (RST_RUN[i])
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .ld         (sel && (cmd_op == LOAD)),
      .start      (sel && (cmd_op == START)),
      .stop       (sel && (cmd_op == STOP)),
      .toggle     (sel && (cmd_op == TOGGLE_MODE)),
      .ld_period  (cmd_period),
      .ld_oneshot (cmd_oneshot),
      .tick       (tick[i]),
      .clk_slow   (clk_slow[i]),
      .running    (running[i])
    );
  end

endmodule
